// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   - rx_state_e      : receiver FSM state encoding
//   - PRESCALE_*      : legal clocks-per-bit settings
//   - PAR_EVEN/PAR_ODD: parity-type select values
//   - legal_prescale  : maps illegal prescale settings onto 8
//   - majority3       : 2-of-3 vote used by the bit sampler
package uart_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Anything other than 8/16/32 falls back to 8 clocks per bit.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
        logic [PRESCALE_W-1:0] r;
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
            default:                              r = PRESCALE_8;
        endcase
        return r;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   rx_in       : serial line
//   active      : high while a frame is being received; low holds the counter at 0
//   prescale    : clocks per bit (already legalised)
//   bit_val_c   : voted bit value, valid when bit_done_c is high
//   bit_done_c  : high in the last clock of each bit (edge count == prescale-1)
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_val_c,
    output logic                  bit_done_c
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]            samp_q, samp_d;
    logic [PRESCALE_W-1:0] half_c, last_c;

    // Counter advance and mid-bit sample capture.
    always_comb begin
        half_c     = prescale >> 1;
        last_c     = prescale - PRESCALE_W'(1);
        edge_cnt_d = edge_cnt_q;
        samp_d     = samp_q;
        if (!active) begin
            edge_cnt_d = '0;
        end else begin
            if (edge_cnt_q == last_c) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
            if (edge_cnt_q == half_c - PRESCALE_W'(1)) begin
                samp_d[0] = rx_in;
            end
            if (edge_cnt_q == half_c) begin
                samp_d[1] = rx_in;
            end
            if (edge_cnt_q == half_c + PRESCALE_W'(1)) begin
                samp_d[2] = rx_in;
            end
        end
    end

    // Sample/counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            samp_q     <= 3'b111;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
        end
    end

    // All three samples are taken well before the last count, so the vote is stable here.
    assign bit_done_c = active && (edge_cnt_q == last_c);
    assign bit_val_c  = majority3(samp_q[0], samp_q[1], samp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first data, optional parity, stop check.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   RX_IN       : serial line (idle high), already synchronised
//   Prescale    : clocks per bit, 8/16/32 (others treated as 8), latched at frame start
//   Par_En      : parity bit present, latched at frame start
//   Par_Typ     : 0 even, 1 odd, latched at frame start
//   P_DATA      : last good byte
//   Data_Valid  : one-clock pulse when P_DATA is loaded with a good frame
//   Par_Err     : parity error of the last completed frame
//   Stp_Err     : stop-bit error of the last completed frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_err_int_q, par_err_int_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  start_frame;
    logic                  par_exp;
    logic                  frame_par_err;
    logic                  frame_stp_err;
    logic                  samp_active_c;
    logic                  samp_bit_c;
    logic                  samp_done_c;

    assign samp_active_c = (state_q != IDLE);

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (RX_IN),
        .active     (samp_active_c),
        .prescale   (prescale_q),
        .bit_val_c  (samp_bit_c),
        .bit_done_c (samp_done_c)
    );

    // Next-state, datapath and output computation.
    always_comb begin
        state_d       = state_q;
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        par_err_int_d = par_err_int_q;
        p_data_d      = p_data_q;
        data_valid_d  = 1'b0;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        start_frame   = 1'b0;
        par_exp       = 1'b0;
        frame_par_err = 1'b0;
        frame_stp_err = 1'b0;

        case (state_q)
            IDLE: begin
                start_frame = ~RX_IN;
            end
            START: begin
                if (samp_done_c) begin
                    // A high vote means the falling edge was a glitch.
                    state_d = samp_bit_c ? IDLE : DATA;
                end
            end
            DATA: begin
                if (samp_done_c) begin
                    shift_d = {samp_bit_c, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                case (par_typ_q)
                    PAR_EVEN: par_exp = ^shift_q;
                    PAR_ODD:  par_exp = ~^shift_q;
                endcase
                if (samp_done_c) begin
                    if (samp_bit_c != par_exp) begin
                        par_err_int_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (samp_done_c) begin
                    frame_par_err = par_en_q & par_err_int_q;
                    frame_stp_err = ~samp_bit_c;
                    par_err_d     = frame_par_err;
                    stp_err_d     = frame_stp_err;
                    if (!frame_par_err && !frame_stp_err) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                    // The exit edge also samples the line as IDLE would, so a start bit
                    // that follows the stop bit with no gap keeps the bit-period spacing.
                    start_frame = ~RX_IN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start: capture configuration and clear per-frame state.
        if (start_frame) begin
            state_d       = START;
            prescale_d    = legal_prescale(Prescale);
            par_en_d      = Par_En;
            par_typ_d     = Par_Typ;
            bit_idx_d     = '0;
            par_err_int_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prescale_q    <= PRESCALE_8;
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_err_int_q <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_err_int_q <= par_err_int_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;

endmodule
